// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot(
    input logic [IDX_W-1:0] idx
  );
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority search: first set req bit at or after start,
// wrapping 7->0.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    found = |req;
    idx   = '0;
    pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = start + IDX_W'(k);
      if (req[pos]) begin
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold-until-release grants.
// Optional hold timeout enabled by defining RR_ARBITER8_TIMEOUT_EN.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             release_i,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout_o
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;

  logic             busy;
  logic             rel_own;
  logic             force_rel;
  logic             end_grant;
  logic             new_grant;
  logic [IDX_W-1:0] start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  assign busy    = (state_q == BUSY);
  assign rel_own = release_i | ~req[idx_q];

  // While busy the last-served index is the current owner.
  assign start = busy ? idx_q + 3'd1
                      : last_q + 3'd1;

  rr_pick u_pick (
    .req   (req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign force_rel = busy & ~rel_own
                   & (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  assign end_grant = busy & (rel_own | force_rel);
  assign new_grant = pick_found & (~busy | end_grant);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          grant_d = onehot(pick_idx);
          idx_d   = pick_idx;
          valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (end_grant) begin
          last_d = idx_q;
          to_d   = force_rel;
          if (pick_found) begin
            grant_d = onehot(pick_idx);
            idx_d   = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= 3'd7;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized
// traffic against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       release_i;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout_o;

  int n_pass;
  int n_total;

  bit m_busy;
  int m_owner;
  int m_last;
  int m_hold;
  bit m_to;

  rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .release_i   (release_i),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int scan(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (from + k) % 8;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] e_grant();
    logic [7:0] g;
    g = 8'h00;
    if (m_busy) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 7;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic rel);
    bit ending;
    bit forced;
    m_to = 1'b0;
    if (!m_busy) begin
      if (r != 8'h00) begin
        m_owner = scan(r, (m_last + 1) % 8);
        m_busy  = 1'b1;
        m_hold  = 1;
      end
    end else begin
      ending = rel || !r[m_owner];
      forced = 1'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
      if (!ending && m_hold >= HOLD) begin
        ending = 1'b1;
        forced = 1'b1;
      end
`endif
      if (ending) begin
        m_last = m_owner;
        m_to   = forced;
        if (r != 8'h00) begin
          m_owner = scan(r, (m_owner + 1) % 8);
          m_hold  = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rel);
    req       = r;
    release_i = rel;
    @(posedge clk);
    model_edge(r, rel);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = 8'h00;
    release_i = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({grant, grant_idx, grant_valid, timeout_o} !== 13'h0)
      $display("FAIL reset_init: got g=%h i=%0d v=%b t=%b want zeros",
               grant, grant_idx, grant_valid, timeout_o);
    else n_pass++;
    do_reset();
    step(8'hFF, 1'b0);
    n_total++;
    if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1)
      $display("FAIL reset_first: got g=%h i=%0d want g=01 i=0",
               grant, grant_idx);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({grant, grant_valid, timeout_o} !== 10'h0)
      $display("FAIL reset_async: got g=%h v=%b t=%b want zeros",
               grant, grant_valid, timeout_o);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 1'b0);
    n_total++;
    if (grant_idx !== 3'd0 || grant !== 8'h01)
      $display("FAIL reset_ptr: got i=%0d want 0", grant_idx);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    step(8'h08, 1'b0);
    n_total++;
    if (grant !== 8'h08 || grant_idx !== 3'd3 || grant_valid !== 1'b1)
      $display("FAIL single_grant: got g=%h i=%0d v=%b want 08 3 1",
               grant, grant_idx, grant_valid);
    else n_pass++;
    step(8'h00, 1'b0);
    n_total++;
    if (grant !== 8'h00 || grant_idx !== 3'd3 || grant_valid !== 1'b0)
      $display("FAIL single_drop: got g=%h i=%0d v=%b want 00 3 0",
               grant, grant_idx, grant_valid);
    else n_pass++;
  endtask

  task automatic test_rotation();
    do_reset();
    step(8'hFF, 1'b0);
    n_total++;
    if (grant_idx !== 3'd0)
      $display("FAIL rot_first: got i=%0d want 0", grant_idx);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      step(8'hFF, 1'b1);
      n_total++;
      if (grant_idx !== 3'(i % 8) || grant_valid !== 1'b1)
        $display("FAIL rot_seq: got i=%0d v=%b want %0d 1",
                 grant_idx, grant_valid, i % 8);
      else n_pass++;
    end
    step(8'h00, 1'b1);
  endtask

  task automatic test_wrap();
    do_reset();
    step(8'h20, 1'b0);
    n_total++;
    if (grant_idx !== 3'd5)
      $display("FAIL wrap_5: got i=%0d want 5", grant_idx);
    else n_pass++;
    step(8'h21, 1'b1);
    n_total++;
    if (grant !== 8'h01 || grant_idx !== 3'd0)
      $display("FAIL wrap_0: got g=%h want 01", grant);
    else n_pass++;
    step(8'h21, 1'b1);
    n_total++;
    if (grant !== 8'h20 || grant_idx !== 3'd5)
      $display("FAIL wrap_back: got g=%h want 20", grant);
    else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    step(8'h44, 1'b0);
    n_total++;
    if (grant_idx !== 3'd2 || grant_valid !== 1'b1)
      $display("FAIL hold_first: got i=%0d want 2", grant_idx);
    else n_pass++;
`ifdef RR_ARBITER8_TIMEOUT_EN
    for (int c = 2; c <= HOLD; c++) begin
      step(8'h44, 1'b0);
      n_total++;
      if (grant_idx !== 3'd2 || timeout_o !== 1'b0)
        $display("FAIL hold_keep: got i=%0d t=%b want 2 0",
                 grant_idx, timeout_o);
      else n_pass++;
    end
    step(8'h44, 1'b0);
    n_total++;
    if (grant !== 8'h40 || timeout_o !== 1'b1)
      $display("FAIL hold_force: got g=%h t=%b want 40 1",
               grant, timeout_o);
    else n_pass++;
    step(8'h44, 1'b0);
    n_total++;
    if (grant !== 8'h40 || timeout_o !== 1'b0)
      $display("FAIL hold_pulse: got g=%h t=%b want 40 0",
               grant, timeout_o);
    else n_pass++;
    do_reset();
    step(8'h04, 1'b0);
    for (int c = 2; c <= HOLD; c++) step(8'h04, 1'b0);
    step(8'h04, 1'b0);
    n_total++;
    if (grant !== 8'h04 || grant_valid !== 1'b1 || timeout_o !== 1'b1)
      $display("FAIL hold_regrant: got g=%h v=%b t=%b want 04 1 1",
               grant, grant_valid, timeout_o);
    else n_pass++;
    for (int c = 2; c <= HOLD; c++) begin
      step(8'h04, 1'b0);
      n_total++;
      if (grant !== 8'h04 || timeout_o !== 1'b0)
        $display("FAIL hold_restart: got g=%h t=%b want 04 0",
                 grant, timeout_o);
      else n_pass++;
    end
    step(8'h04, 1'b0);
    n_total++;
    if (timeout_o !== 1'b1)
      $display("FAIL hold_again: got t=%b want 1", timeout_o);
    else n_pass++;
`else
    for (int c = 0; c < 120; c++) begin
      step(8'h44, 1'b0);
      n_total++;
      if (grant_idx !== 3'd2 || grant !== 8'h04 || timeout_o !== 1'b0)
        $display("FAIL hold_forever: cyc=%0d got g=%h t=%b want 04 0",
                 c, grant, timeout_o);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       rel;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 5) == 0) r = 8'h00;
      if (m_busy && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      rel = ($urandom_range(0, 3) == 0);
      step(r, rel);
      n_total++;
      if ({grant, grant_idx, grant_valid, timeout_o} !==
          {e_grant(), 3'(m_owner), m_busy, m_to})
        $display("FAIL rand_step%0d: got g=%h i=%0d v=%b t=%b want g=%h i=%0d v=%b t=%b",
                 n, grant, grant_idx, grant_valid, timeout_o,
                 e_grant(), m_owner, m_busy, m_to);
      else n_pass++;
      if (n == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({grant, grant_idx, grant_valid, timeout_o} !== 13'h0)
          $display("FAIL rand_reset: got g=%h i=%0d want zeros",
                   grant, grant_idx);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 8'h00;
    release_i = 1'b0;
    n_pass    = 0;
    n_total   = 0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
